mem_port_arbiter: RTL and testbench

Shares the single byte-wide unified instruction/data memory between two requesters: the multicycle CPU controller path (fetch, lb, sb) and a debug/loader port used for program download and memory inspection. It handles request/grant, tracks one outstanding read with a configurable fixed latency, and resolves conflicts round-robin. It also produces a stall to the CPU controller so its state machine holds while memory is unavailable or debug halt is active.

---
 rtl/mem_port_arbiter.sv | 87 ++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the unified byte memory between the CPU controller and the debug port.
// Supports one outstanding fixed-latency read; a new grant can overlap the cycle that read data returns.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    input  logic              dbg_halt_i,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t            state_q, state_d;
    logic [2:0]        lat_q, lat_d;
    logic              last_dbg_q, last_dbg_d;
    logic              own_dbg_q, own_dbg_d;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              rv_cycle, can_gnt, cpu_elig, pick_dbg, win_we, rd_gnt, cpu_busy;

    // rv_cycle is the only RD_WAIT cycle where a new access may start
    assign rv_cycle  = (state_q == RD_WAIT) && (lat_q == LAT);
    assign can_gnt   = ~rst & ((state_q == IDLE) | rv_cycle);
    assign cpu_elig  = cpu_req_i & ~dbg_halt_i;
    assign pick_dbg  = dbg_req_i & (~cpu_elig | ~last_dbg_q);
    assign cpu_gnt_o = can_gnt & cpu_elig & ~pick_dbg;
    assign dbg_gnt_o = can_gnt & pick_dbg;
    assign mem_en_o  = cpu_gnt_o | dbg_gnt_o;
    assign win_we    = pick_dbg ? dbg_we_i : cpu_we_i;
    assign mem_we_o  = mem_en_o & win_we;
    assign mem_addr_o  = mem_en_o ? (pick_dbg ? dbg_addr_i : cpu_addr_i) : '0;
    assign mem_wdata_o = mem_en_o ? (pick_dbg ? dbg_wdata_i : cpu_wdata_i) : '0;
    assign rd_gnt    = mem_en_o & ~win_we;

    assign cpu_rvalid_o = ~rst & rv_cycle & ~own_dbg_q;
    assign dbg_rvalid_o = ~rst & rv_cycle & own_dbg_q;
    assign cpu_rdata_o  = rst ? '0 : cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    assign dbg_rdata_o  = rst ? '0 : dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;
    assign cpu_busy     = (state_q == RD_WAIT) & ~own_dbg_q & ~cpu_rvalid_o;
    assign cpu_stall_o  = ~rst & ((cpu_req_i & ~cpu_gnt_o) | cpu_busy | dbg_halt_i);

    always_comb begin
        state_d    = rd_gnt ? RD_WAIT : rv_cycle ? IDLE : state_q;
        lat_d      = rd_gnt ? 3'd1 : rv_cycle ? 3'd0 : (state_q == RD_WAIT) ? lat_q + 3'd1 : lat_q;
        last_dbg_d = mem_en_o ? pick_dbg : last_dbg_q;
        own_dbg_d  = rd_gnt ? pick_dbg : own_dbg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            last_dbg_q  <= 1'b1;
            own_dbg_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            last_dbg_q  <= last_dbg_d;
            own_dbg_q   <= own_dbg_d;
            cpu_rdata_q <= cpu_rdata_o;
            dbg_rdata_q <= dbg_rdata_o;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a latency-L memory model; read data checked through a scoreboard.
module tb_mem_port_arbiter;
    localparam int L = 3;

    logic        clk, rst, fill;
    logic        cpu_req_i, cpu_we_i, dbg_req_i, dbg_we_i, dbg_halt_i;
    logic [31:0] cpu_addr_i, dbg_addr_i, mem_addr_o;
    logic [7:0]  cpu_wdata_i, dbg_wdata_i, mem_wdata_o, mem_rdata_i, cpu_rdata_o, dbg_rdata_o;
    logic        cpu_gnt_o, cpu_rvalid_o, cpu_stall_o, dbg_gnt_o, dbg_rvalid_o, mem_en_o, mem_we_o;
    logic [62:0] all_o;

    typedef struct {logic port; logic [7:0] data;} exp_t;
    exp_t q[$];
    logic order[$];
    logic [7:0] mem [256];
    logic [7:0] golden [256];
    logic [7:0] pipe [L];
    int checks = 0, errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(8), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o), .dbg_halt_i(dbg_halt_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    assign all_o = {cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o, cpu_stall_o, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
                    mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};
    assign mem_rdata_i = mem[pipe[L-1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: writes land on the clock edge, read data appears L cycles after the strobe
    always @(posedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        else if (mem_en_o && mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
        pipe[0] <= mem_addr_o[7:0];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    always @(negedge clk) begin
        if (fill) for (int i = 0; i < 256; i++) golden[i] <= 8'(i) ^ 8'hA5;
        else if (!rst) begin
            if (cpu_rvalid_o || dbg_rvalid_o) begin
                if (q.size() == 0) check("rv_unexpected", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rv_port", {cpu_rvalid_o, dbg_rvalid_o}, e.port ? 2'b01 : 2'b10);
                    check("rv_data", e.port ? dbg_rdata_o : cpu_rdata_o, e.data);
                end
            end
            if (cpu_gnt_o) begin
                if (cpu_we_i) golden[cpu_addr_i[7:0]] <= cpu_wdata_i;
                else q.push_back('{1'b0, golden[cpu_addr_i[7:0]]});
            end
            if (dbg_gnt_o) begin
                if (dbg_we_i) golden[dbg_addr_i[7:0]] <= dbg_wdata_i;
                else q.push_back('{1'b1, golden[dbg_addr_i[7:0]]});
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        nxt();
        rst = 1'b0;
    endtask

    task automatic cpu_set(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        cpu_req_i = r; cpu_we_i = w; cpu_addr_i = {24'd0, a}; cpu_wdata_i = d;
    endtask

    task automatic dbg_set(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        dbg_req_i = r; dbg_we_i = w; dbg_addr_i = {24'd0, a}; dbg_wdata_i = d;
    endtask

    task automatic cpu_rd(input logic [7:0] a);
        logic ok = 1'b0;
        cpu_set(1, 0, a, 0);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (cpu_gnt_o) begin ok = 1'b1; order.push_back(1'b0); end
            nxt();
        end
        cpu_req_i = 1'b0;
        check("cpu_rd_grant", ok, 1);
    endtask

    task automatic dbg_rd(input logic [7:0] a);
        logic ok = 1'b0;
        dbg_set(1, 0, a, 0);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (dbg_gnt_o) begin ok = 1'b1; order.push_back(1'b1); end
            nxt();
        end
        dbg_req_i = 1'b0;
        check("dbg_rd_grant", ok, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        fill = 1'b1; rst = 1'b1;
        cpu_set(1, 0, 8'h10, 0); dbg_set(1, 0, 8'h10, 0); dbg_halt_i = 1'b1;
        @(negedge clk);
        check("reset_outputs", {1'b0, all_o}, 0);
        #1 fill = 1'b0;
        nxt();
        cpu_set(0, 0, 0, 0); dbg_set(0, 0, 0, 0); dbg_halt_i = 1'b0; rst = 1'b0;
        nxt();
        // single CPU read
        cpu_set(1, 0, 8'h10, 0);
        @(negedge clk);
        check("s1_gnt", {cpu_gnt_o, mem_en_o, mem_we_o, cpu_stall_o}, 4'b1100);
        check("s1_addr", mem_addr_o, 32'h10);
        nxt(); cpu_req_i = 1'b0;
        @(negedge clk);
        check("s1_wait", {mem_en_o, cpu_stall_o, cpu_rvalid_o}, 3'b010);
        nxt(); nxt();
        @(negedge clk);
        check("s1_rvalid", {cpu_rvalid_o, cpu_stall_o, cpu_rdata_o}, {2'b10, 8'hB5});
        nxt();
        @(negedge clk);
        check("s1_hold", {cpu_rvalid_o, cpu_rdata_o}, {1'b0, 8'hB5});
        // simultaneous writes after reset, then round-robin on repeated ties
        do_reset();
        cpu_set(1, 1, 8'h20, 8'h11); dbg_set(1, 1, 8'h30, 8'h22);
        @(negedge clk);
        check("s2_tie1", {cpu_gnt_o, dbg_gnt_o, mem_we_o, mem_wdata_o}, {3'b101, 8'h11});
        check("s2_addr1", mem_addr_o, 32'h20);
        nxt(); cpu_req_i = 1'b0;
        @(negedge clk);
        check("s2_dbg", {cpu_gnt_o, dbg_gnt_o, mem_we_o, mem_wdata_o}, {3'b011, 8'h22});
        check("s2_addr2", mem_addr_o, 32'h30);
        nxt(); dbg_req_i = 1'b0; cpu_set(1, 1, 8'h21, 8'h33);
        @(negedge clk);
        check("s2_cpu_alone", {cpu_gnt_o, dbg_gnt_o}, 2'b10);
        nxt(); cpu_set(1, 1, 8'h22, 8'h44); dbg_set(1, 1, 8'h31, 8'h55);
        @(negedge clk);
        check("s2_tie2", {cpu_gnt_o, dbg_gnt_o}, 2'b01);
        nxt(); dbg_req_i = 1'b0;
        @(negedge clk);
        check("s2_cpu_after", {cpu_gnt_o, dbg_gnt_o}, 2'b10);
        nxt(); cpu_req_i = 1'b0;
        // CPU read with a debug read queued behind it
        cpu_set(1, 0, 8'h20, 0);
        @(negedge clk);
        check("s3_cpu_gnt", cpu_gnt_o, 1);
        nxt(); cpu_req_i = 1'b0; dbg_set(1, 0, 8'h30, 0);
        for (int i = 0; i < L - 1; i++) begin
            @(negedge clk);
            check("s3_blocked", {dbg_gnt_o, mem_en_o}, 2'b00);
            nxt();
        end
        @(negedge clk);
        check("s3_overlap", {cpu_rvalid_o, cpu_rdata_o, dbg_gnt_o}, {1'b1, 8'h11, 1'b1});
        check("s3_addr", mem_addr_o, 32'h30);
        nxt(); dbg_req_i = 1'b0;
        for (int i = 0; i < L - 1; i++) begin
            @(negedge clk);
            check("s3_dbg_wait", dbg_rvalid_o, 0);
            nxt();
        end
        @(negedge clk);
        check("s3_dbg_rv", {dbg_rvalid_o, dbg_rdata_o}, {1'b1, 8'h22});
        nxt();
        // halt arrives while a CPU read is outstanding
        cpu_set(1, 0, 8'h21, 0);
        @(negedge clk);
        check("s4_gnt", cpu_gnt_o, 1);
        nxt(); dbg_halt_i = 1'b1; cpu_set(1, 0, 8'h22, 0);
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check("s4_halt_rd", {cpu_gnt_o, cpu_stall_o, cpu_rvalid_o}, {2'b01, i == L});
            nxt();
        end
        for (int i = 0; i < 5; i++) begin
            dbg_set(1, 1, 8'(8'h50 + i), 8'(8'h60 + i));
            @(negedge clk);
            check("s4_halt", {cpu_gnt_o, dbg_gnt_o, cpu_stall_o}, 3'b011);
            nxt();
        end
        dbg_req_i = 1'b0; dbg_halt_i = 1'b0;
        @(negedge clk);
        check("s4_release", {cpu_gnt_o, cpu_stall_o}, 2'b10);
        nxt(); cpu_req_i = 1'b0;
        repeat (L) nxt();
        // reset in the middle of a read
        cpu_set(1, 0, 8'h10, 0);
        @(negedge clk);
        check("s5_gnt", cpu_gnt_o, 1);
        nxt(); rst = 1'b1; q.delete(); dbg_set(1, 0, 8'h10, 0);
        @(negedge clk);
        check("s5_rst_outputs", {1'b0, all_o}, 0);
        nxt(); rst = 1'b0; cpu_req_i = 1'b0; dbg_req_i = 1'b0;
        for (int i = 0; i < L + 1; i++) begin
            @(negedge clk);
            check("s5_no_rv", {cpu_rvalid_o, dbg_rvalid_o}, 2'b00);
            nxt();
        end
        cpu_set(1, 0, 8'h11, 0); dbg_set(1, 0, 8'h12, 0);
        @(negedge clk);
        check("s5_tie", {cpu_gnt_o, dbg_gnt_o}, 2'b10);
        nxt(); cpu_req_i = 1'b0;
        repeat (L - 1) nxt();
        @(negedge clk);
        check("s5_dbg_gnt", dbg_gnt_o, 1);
        nxt(); dbg_req_i = 1'b0;
        repeat (L) nxt();
        // continuous contention from both ports
        order.delete();
        fork
            for (int k = 0; k < 4; k++) cpu_rd(8'(8'h60 + k));
            for (int k = 0; k < 4; k++) dbg_rd(8'(8'h50 + k));
        join
        repeat (L + 1) nxt();
        check("s6_count", order.size(), 8);
        for (int k = 0; k < 8 && k < order.size(); k++) check("s6_alternate", order[k], k % 2);
        check("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
